// File: rtl/tiny_prog_loader_pkg.sv
// Shared definitions for the program loader: header command codes and FSM state encoding.
package tiny_pkg;
  localparam logic [1:0] CMD_NOP  = 2'b00;
  localparam logic [1:0] CMD_LOAD = 2'b01;
  localparam logic [1:0] CMD_RUN  = 2'b10;
  localparam logic [1:0] CMD_HALT = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ADDR  = 2'd1,
    ST_COUNT = 2'd2,
    ST_DATA  = 2'd3
  } state_e;
endpackage

// File: rtl/tiny_prog_loader_if.sv
// Host byte link plus program-memory write port and core gating, as seen by the loader.
interface tiny_prog_loader_if #(
  parameter int ADDR_W  = 5,
  parameter int INSTR_W = 16
);
  logic [7:0]         din;
  logic               strb_in;
  logic               ack_out;
  logic               mem_we;
  logic [ADDR_W-1:0]  mem_addr;
  logic [INSTR_W-1:0] mem_wdata;
  logic               core_run;
  logic               loading;
  logic [7:0]         chk_sum;

  modport master (
    output din, strb_in,
    input  ack_out, mem_we, mem_addr, mem_wdata, core_run, loading, chk_sum
  );
  modport slave (
    input  din, strb_in,
    output ack_out, mem_we, mem_addr, mem_wdata, core_run, loading, chk_sum
  );
endinterface

// File: rtl/tiny_prog_loader_toggle.sv
// Registered toggle detector; the history register tracks the input during reset so a
// strobe already high at reset release is not seen as an edge.
module tiny_toggle_edge (
  input  logic clk,
  input  logic rst,
  input  logic tog_i,
  output logic evt_o
);
  logic tog_q;

  always_ff @(posedge clk) tog_q <= tog_i;

  assign evt_o = ~rst & (tog_i ^ tog_q);
endmodule

// File: rtl/tiny_prog_loader.sv
// Byte-serial program loader: decodes host headers, assembles MSB-first instruction
// words, writes program memory and gates core execution.
module tiny_prog_loader
  import tiny_pkg::*;
#(
  parameter int ADDR_W  = 5,
  parameter int INSTR_W = 16
) (
  input logic          clk,
  input logic          rst,
  tiny_prog_loader_if.slave bus
);
  localparam int BPW  = INSTR_W / 8;
  localparam int BI_W = (BPW > 1) ? $clog2(BPW) : 1;
  localparam logic [BI_W-1:0] LAST_BYTE = BI_W'(BPW - 1);

  state_e             state_q, state_d;
  logic               ack_q, ack_d;
  logic               we_q, we_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [INSTR_W-1:0] wdata_q, wdata_d;
  logic [INSTR_W-1:0] shift_q, shift_d;
  logic               run_q, run_d;
  logic               load_q, load_d;
  logic [7:0]         sum_q, sum_d;
  logic [7:0]         cnt_q, cnt_d;
  logic [BI_W-1:0]    bidx_q, bidx_d;
  logic [INSTR_W-1:0] word;
  logic               evt;

  tiny_toggle_edge u_edge (
    .clk  (clk),
    .rst  (rst),
    .tog_i(bus.strb_in),
    .evt_o(evt)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      ack_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      shift_q <= '0;
      run_q   <= 1'b0;
      load_q  <= 1'b0;
      sum_q   <= '0;
      cnt_q   <= '0;
      bidx_q  <= '0;
    end else begin
      state_q <= state_d;
      ack_q   <= ack_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      shift_q <= shift_d;
      run_q   <= run_d;
      load_q  <= load_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      bidx_q  <= bidx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ack_d   = ack_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    shift_d = shift_q;
    run_d   = run_q;
    load_d  = load_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    bidx_d  = bidx_q;
    word    = INSTR_W'({shift_q, bus.din});

    // Post-increment happens in the cycle the write is presented, so mem_addr is stable for it.
    if (we_q) addr_d = addr_q + 1'b1;

    if (evt) begin
      ack_d = ~ack_q;
      unique case (state_q)
        ST_IDLE: begin
          case (bus.din[7:6])
            CMD_NOP:  ;
            CMD_LOAD: begin
              state_d = ST_ADDR;
              run_d   = 1'b0;
              load_d  = 1'b1;
              sum_d   = '0;
            end
            CMD_RUN:  run_d = 1'b1;
            CMD_HALT: run_d = 1'b0;
            default:  ;
          endcase
        end
        ST_ADDR: begin
          addr_d  = bus.din[ADDR_W-1:0];
          state_d = ST_COUNT;
        end
        ST_COUNT: begin
          if (bus.din == 8'd0) begin
            state_d = ST_IDLE;
            load_d  = 1'b0;
          end else begin
            cnt_d   = bus.din;
            bidx_d  = '0;
            state_d = ST_DATA;
          end
        end
        ST_DATA: begin
          sum_d   = sum_q + bus.din;
          shift_d = word;
          if (bidx_q == LAST_BYTE) begin
            wdata_d = word;
            we_d    = 1'b1;
            bidx_d  = '0;
            cnt_d   = cnt_q - 8'd1;
            if (cnt_q == 8'd1) begin
              state_d = ST_IDLE;
              load_d  = 1'b0;
            end
          end else begin
            bidx_d = bidx_q + 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  assign bus.ack_out   = ack_q;
  assign bus.mem_we    = we_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.core_run  = run_q;
  assign bus.loading   = load_q;
  assign bus.chk_sum   = sum_q;
endmodule

// File: tb/tb_tiny_prog_loader.sv
// Scoreboarded random bench for tiny_prog_loader: command-level model pushes expected
// memory writes; a monitor pops and compares them whenever mem_we is seen.
module tb_tiny_prog_loader;
  localparam int AW    = 5;
  localparam int IW    = 16;
  localparam int BPW   = IW / 8;
  localparam int DEPTH = 1 << AW;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [IW-1:0] d;
  } wr_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  tiny_prog_loader_if #(.ADDR_W(AW), .INSTR_W(IW)) bus ();
  tiny_prog_loader #(.ADDR_W(AW), .INSTR_W(IW)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  wr_t        exp_q[$];
  logic [7:0] payload[$];
  int         checks   = 0;
  int         failures = 0;
  int         acks     = 0;
  bit         exp_run  = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: counts ack toggles and checks every presented write against the scoreboard.
  initial begin
    wr_t  e;
    logic ack_prev;
    ack_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (bus.ack_out !== ack_prev) acks++;
        if (bus.mem_we === 1'b1) begin
          chk("we_while_run", 32'(bus.core_run), 32'd0);
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_write: got addr %0h data %0h expected none",
                     bus.mem_addr, bus.mem_wdata);
          end else begin
            e = exp_q.pop_front();
            chk("wr_addr", 32'(bus.mem_addr), 32'(e.a));
            chk("wr_data", 32'(bus.mem_wdata), 32'(e.d));
          end
        end
      end
      ack_prev = bus.ack_out;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic send_byte(input logic [7:0] b);
    logic a0;
    bit   got;
    @(negedge clk);
    a0 = bus.ack_out;
    bus.din = b;
    bus.strb_in = ~bus.strb_in;
    got = 1'b0;
    for (int i = 0; i < 8 && !got; i++) begin
      @(negedge clk);
      if (bus.ack_out !== a0) got = 1'b1;
    end
    chk("ack_timeout", 32'(got), 32'd1);
  endtask

  task automatic header(input logic [7:0] b);
    send_byte(b);
    case (b[7:6])
      2'b10:   exp_run = 1'b1;
      2'b01:   exp_run = 1'b0;
      2'b11:   exp_run = 1'b0;
      default: ;
    endcase
    chk("hdr_core_run", 32'(bus.core_run), 32'(exp_run));
  endtask

  task automatic fill_rand(input int n);
    payload.delete();
    repeat (n * BPW) payload.push_back(8'($urandom));
  endtask

  // Whole LOAD transaction at command level; expected words/addresses from plain arithmetic.
  task automatic do_load(input logic [7:0] abyte, input int n);
    int         sum;
    logic [IW-1:0] w;
    header({2'b01, 6'($urandom)});
    chk("load_loading_hi", 32'(bus.loading), 32'd1);
    chk("load_sum_clr", 32'(bus.chk_sum), 32'd0);
    send_byte(abyte);
    send_byte(8'(n));
    sum = 0;
    for (int k = 0; k < n; k++) begin
      w = '0;
      for (int j = 0; j < BPW; j++) w = (w << 8) | IW'(payload[k*BPW+j]);
      exp_q.push_back('{a: AW'((int'(abyte) % DEPTH + k) % DEPTH), d: w});
      for (int j = 0; j < BPW; j++) begin
        sum = (sum + int'(payload[k*BPW+j])) % 256;
        send_byte(payload[k*BPW+j]);
      end
    end
    chk("load_loading_lo", 32'(bus.loading), 32'd0);
    chk("load_chk_sum", 32'(bus.chk_sum), 32'(sum));
    chk("load_core_run", 32'(bus.core_run), 32'd0);
    repeat (2) @(negedge clk);
    chk("load_writes_done", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    int a0;
    bus.din = 8'h00;
    bus.strb_in = 1'b1;

    // T1: strobe high through reset is not an edge
    repeat (3) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t1_ack", 32'(bus.ack_out), 32'd0);
    end
    chk("t1_outs", {bus.mem_we, bus.core_run, bus.loading, bus.chk_sum, bus.mem_addr, bus.mem_wdata}, 32'd0);

    // T2: fixed payload
    payload.delete();
    payload.push_back(8'h12); payload.push_back(8'h34);
    payload.push_back(8'hAB); payload.push_back(8'hCD);
    a0 = acks;
    do_load(8'h03, 2);
    chk("t2_ack_count", 32'(acks - a0), 32'd7);

    // T3: address wrap, upper address bits ignored
    fill_rand(2);
    do_load(8'hFF, 2);

    // T4: RUN, then LOAD with N=0
    header(8'h80);
    do_load(8'h00, 0);

    // T5: reset mid-load discards the partial word
    header(8'h40);
    send_byte(8'h05);
    send_byte(8'h01);
    send_byte(8'h5A);
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    exp_run = 1'b0;
    chk("t5_rst_outs", {bus.ack_out, bus.core_run, bus.loading, bus.chk_sum}, 32'd0);
    repeat (3) @(negedge clk);
    header(8'hC0);
    header(8'h80);

    // T6: HALT / RUN while running
    header(8'hC0);
    header(8'h80);

    // Random command mix
    for (int it = 0; it < 30; it++) begin
      case ($urandom_range(0, 3))
        0: header({2'b00, 6'($urandom)});
        1: header({2'b10, 6'($urandom)});
        2: header({2'b11, 6'($urandom)});
        default: begin
          a0 = int'($urandom_range(0, 4));
          fill_rand(a0);
          do_load(8'($urandom), a0);
        end
      endcase
      chk("rand_loading", 32'(bus.loading), 32'd0);
    end

    repeat (3) @(negedge clk);
    chk("final_queue", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
